// File: rtl/cmp_seq_pkg.sv
// Shared types for the sequential nibble comparator: FSM states and the GT/LT/EQ cascade word.
// Optional two's-complement compare is enabled in cmp_seq_ctrl by defining CMP_SEQ_SIGNED_EN.
package cmp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_res_t;

  localparam cmp_res_t RES_EQUAL = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};
  localparam cmp_res_t RES_CLEAR = '{gt: 1'b0, lt: 1'b0, eq: 1'b0};

  // A single-nibble compare still needs one counter bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nib_cmp_slice.sv
// Combinational 4-bit magnitude comparator slice with cascade inputs.
// A differing nibble decides the result; an equal nibble forwards the cascade unchanged.
import cmp_seq_pkg::*;

module nib_cmp_slice (
  input  logic [3:0] a_nib,
  input  logic [3:0] b_nib,
  input  cmp_res_t   cas_in,
  output cmp_res_t   cas_out
);

  always_comb begin
    cas_out = cas_in;
    if (a_nib > b_nib) begin
      cas_out = '{gt: 1'b1, lt: 1'b0, eq: 1'b0};
    end else if (a_nib < b_nib) begin
      cas_out = '{gt: 1'b0, lt: 1'b1, eq: 1'b0};
    end
  end

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Sequential magnitude comparator: walks the operands one nibble per cycle, LSB first, through one slice.
// Define CMP_SEQ_SIGNED_EN to compare the operands as two's complement instead of unsigned.
import cmp_seq_pkg::*;

module cmp_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic                 qagb,
  output logic                 qasb,
  output logic                 qaeb
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  cmp_res_t        cas_q, cas_d;
  cmp_res_t        res_q, res_d;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  cmp_res_t        slice_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cas_q   <= RES_EQUAL;
      res_q   <= RES_CLEAR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cas_q   <= cas_d;
      res_q   <= res_d;
    end
  end

  // Nibble mux; the top nibble's sign bit is flipped so an unsigned slice orders two's complement.
  always_comb begin
    a_nib = a_q[3:0];
    b_nib = b_q[3:0];
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
`ifdef CMP_SEQ_SIGNED_EN
    if (cnt_q == LAST_CNT) begin
      a_nib[3] = ~a_nib[3];
      b_nib[3] = ~b_nib[3];
    end
`else
`endif
  end

  nib_cmp_slice u_slice (
    .a_nib   (a_nib),
    .b_nib   (b_nib),
    .cas_in  (cas_q),
    .cas_out (slice_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cas_d   = cas_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          cas_d   = RES_EQUAL;
        end
      end
      ST_RUN: begin
        cas_d = slice_res;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FIN;
          res_d   = slice_res;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FIN);
  assign qagb = res_q.gt;
  assign qasb = res_q.lt;
  assign qaeb = res_q.eq;

endmodule

// File: doc/cmp_seq_ctrl.md
CMP_SEQ_CTRL -- requirements
Module: cmp_seq_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the number of 4-bit nibbles compared; operand width is 4*NIBBLES; legal range 1..8.
REQ-002 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 RST_N  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 START  input  1  SHALL be the compare request; it SHALL be sampled only in IDLE.
REQ-005 A  input  4*NIBBLES  SHALL be operand A, captured on the accepted START edge.
REQ-006 B  input  4*NIBBLES  SHALL be operand B, captured on the accepted START edge.
REQ-007 BUSY  output  1  SHALL be high in RUN and FIN, low in IDLE.
REQ-008 DONE  output  1  SHALL be a one-cycle pulse, high only in FIN.
REQ-009 QAGB, QASB, QAEB  output  1 each  SHALL be the registered A>B, A<B and A=B results, exactly one-hot once any compare completes.

Function
REQ-010 States SHALL be IDLE, RUN and FIN; IDLE->RUN on START=1; RUN->FIN when nibble counter = NIBBLES-1; FIN->IDLE unconditionally.
REQ-011 On the accepted START edge, operands SHALL be latched, counter cleared to 0, and cascade register set to equal (GT=0, LT=0, EQ=1).
REQ-012 Each RUN cycle SHALL compare nibble[cnt] of latched A and B, LSB nibble first, through one comparator slice; the slice cascade inputs come from the cascade register, and the slice result is written back to it.
REQ-013 Slice rule: nibble A>B gives GT; nibble A<B gives LT; equal nibbles pass the cascade inputs through unchanged.
REQ-014 On the RUN->FIN edge, the final slice result SHALL be loaded into QAGB/QASB/QAEB.
REQ-015 Latency: with START accepted at edge k, DONE and valid results SHALL appear in the cycle after edge k+NIBBLES; the cycle-to-cycle throughput SHALL be one compare per NIBBLES+2 cycles.
REQ-016 START while BUSY=1 SHALL be ignored; changes to A and B after acceptance SHALL NOT affect the result.
REQ-017 QAGB/QASB/QAEB SHALL hold their last value through IDLE until the next FIN.
REQ-018 The counter SHALL be ceil(log2(NIBBLES)) bits (minimum 1) and SHALL never exceed NIBBLES-1.

Reset
REQ-019 RST_N low SHALL force IDLE, counter 0, cascade register to equal, BUSY=0, DONE=0, and QAGB=QASB=QAEB=0, in any state, including mid-RUN.
REQ-020 After reset release, the first START SHALL be accepted on the first rising edge where START=1.

Configuration
REQ-021 With CMP_SEQ_SIGNED_EN defined, operands SHALL be compared as two's complement by inverting bit 3 of the most-significant nibble of both A and B before the slice; without it, the compare SHALL be unsigned.

Structure
REQ-022 A shared package cmp_seq_pkg SHALL hold the state enum (IDLE/RUN/FIN) and the cascade result type (GT/LT/EQ bits).
REQ-023 The combinational 4-bit slice with cascade inputs SHALL be a separate sub-module, nib_cmp_slice; cmp_seq_ctrl SHALL instantiate it exactly once.

Verification
REQ-024 A=0x1234, B=0x1234, START pulse -> BUSY high for 5 cycles, DONE single pulse 4 cycles after START edge, QAEB=1, QAGB=QASB=0.
REQ-025 A=0x8001, B=0x7FFF, unsigned -> QAGB=1; with CMP_SEQ_SIGNED_EN -> QASB=1.
REQ-026 A=0x00F0, B=0x00EF -> QAGB=1 (an LSB-nibble LT overridden by a higher nibble GT); A=0x0010, B=0x001F -> QASB=1.
REQ-027 START held high continuously with A/B changing every cycle -> compares spaced 6 cycles apart, each result matching the operands at its accepted edge.
REQ-028 RST_N asserted in RUN cycle 2 -> all outputs 0 immediately; a new START after release gives a correct result.
REQ-029 NIBBLES=1, A=0x5, B=0x9 -> DONE one cycle after the START edge, QASB=1.
